mul_result_acc: RTL and testbench
=================================

# mul_result_acc

Downstream accumulation stage for the shift-add signed multiplier. It consumes one `product` per handshake and sums a programmed number of products into a guard-bit-extended signed accumulator. It then presents the total with a valid/ready handshake. Together with the multiplier it forms a sequential dot-product / MAC datapath.

## Interface
- `WIDTH`, 32: multiplier operand width.
- `PROD_W`, 2*WIDTH+1: product width, equal to the multiplier's `product` output width.
- `ACC_GUARD`, 8: guard bits above `PROD_W`.
- `ACC_W`, PROD_W+ACC_GUARD: accumulator width.
- `MAX_TERMS`, 16: maximum products per accumulation.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next edge.
- `start`  in  1  begin accumulation; sampled only in IDLE.
- `num_terms`  in  $clog2(MAX_TERMS+1)  number of products to sum; sampled with `start`.
- `product`  in  PROD_W  signed product from the multiplier.
- `prod_valid`  in  1  `product` is valid.
- `prod_ready`  out  1  stage accepts `product`.
- `acc_out`  out  ACC_W  signed accumulated result.
- `acc_valid`  out  1  `acc_out` is final.
- `acc_ready`  in  1  consumer takes `acc_out`.
- `overflow`  out  1  sticky; an add overflowed `ACC_W` during this accumulation.
- `busy`  out  1  state is not IDLE.
- `term_count`  out  $clog2(MAX_TERMS+1)  products accepted so far.

## Operation
- FSM states: IDLE, ACCUM, DONE. All outputs are registered or decoded from the state only.
- IDLE, `start`=1, `num_terms`≠0: latch `num_terms`, clear the accumulator, `term_count` and `overflow`, then go to ACCUM.
- IDLE, `start`=1, `num_terms`=0: clear the accumulator, then go to DONE. The result is 0.
- `num_terms` > `MAX_TERMS` is clamped to `MAX_TERMS`.
- ACCUM: `prod_ready`=1. A transfer occurs when `prod_valid` && `prod_ready`.
- On each transfer, `acc_out` ← `acc_out` + sign-extended `product`, and `term_count` increments.
- The transfer that makes `term_count` equal the latched count moves the FSM to DONE.
- Gaps in `prod_valid` stall the FSM with no state change.
- DONE: `acc_valid`=1. `acc_out`, `overflow` and `term_count` are held stable until `acc_ready`=1. The FSM then returns to IDLE, and `acc_valid` drops on that edge.
- `start` is ignored outside IDLE.
- Overflow detection: the operand signs match and the result sign differs. `overflow` stays set until the next accepted `start` or `reset`.
- `reset` asserted in any state, including mid-accumulation:
  - the next edge forces IDLE;
  - `acc_out`=0, `term_count`=0, `overflow`=0, `acc_valid`=0;
  - the partial sum is discarded.

## Timing
- Reset values: `prod_ready`=0, `acc_valid`=0, `busy`=0, `acc_out`=0, `overflow`=0, `term_count`=0.
- Cycle after `start`: `busy`=1, and `prod_ready`=1 (or `acc_valid`=1 when `num_terms`=0).
- Throughput: one product per cycle while `prod_valid` is held high.
- Latency: `acc_valid`=1 in the cycle after the last accepted transfer.
- Minimum N-term run: 1 (start) + N (terms) + 1 (DONE handshake) cycles.
- `prod_ready` is 0 in IDLE and DONE. The upstream multiplier therefore holds its product until this stage is in ACCUM.

## Configuration
- `MUL_ACC_SAT_EN` defined:
  - on overflow the accumulator clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1), following the sign of the addends;
  - it stays clamped in that direction for further same-sign overflows;
  - `overflow` is set.
- Undefined: two's-complement wrap-around. `overflow` is still set. No saturation logic is synthesized.

## Structure
- Shared package `mul_pkg`:
  - FSM state enum (IDLE/ACCUM/DONE);
  - default `WIDTH`;
  - the `PROD_W` derivation, shared with the multiplier so the widths cannot diverge.
- Sub-module `acc_sat_adder`: combinational ACC_W signed adder with overflow output and an optional clamp under `MUL_ACC_SAT_EN`.
- FSM, counter and handshake logic live in `mul_result_acc`.

## Test plan
- Sum of three products: WIDTH=32; `num_terms`=3; products 15, -4, 4 sent back-to-back.
  - `acc_out`=15, `overflow`=0, `term_count`=3.
  - `acc_valid` asserts 1 cycle after the third transfer.
- Bubbles and back-pressure: `num_terms`=2; products -4611686014132420609 and 4611686018427387904 with 3 idle cycles between them; `acc_ready` held low 5 cycles.
  - `acc_out`=4294967295, held stable while `acc_ready`=0.
  - IDLE on the edge `acc_ready`=1.
- Zero terms: `start` with `num_terms`=0.
  - Next cycle `acc_valid`=1, `acc_out`=0, `prod_ready` never asserted.
- Overflow: WIDTH=4, ACC_GUARD=1 (ACC_W=10); 8 products of 64.
  - With `MUL_ACC_SAT_EN`: `acc_out`=511, `overflow`=1.
  - Without it: `acc_out`=-512, `overflow`=1.
- Reset mid-operation: `num_terms`=4; assert `reset` after 2 transfers.
  - Next cycle: `busy`=0, `acc_out`=0, `term_count`=0, `prod_ready`=0.
  - A new `start` with 1 term of 7 gives `acc_out`=7.
- `start` pulsed during ACCUM and DONE: no effect; the result matches the unperturbed run.

Source files
------------

// File: rtl/mul_pkg.sv
// ============================================================================
// Module  : mul_pkg
// Purpose : Shared definitions for the shift-add multiplier datapath and its
//           downstream accumulation stage.
//           - default operand width
//           - product width derivation (used by both blocks so they agree)
//           - accumulation FSM state encoding
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mul_pkg;

    // Default multiplier operand width.
    localparam int c_default_width = 32;

    // The product carries one extra bit beyond 2*WIDTH.  This is the single
    // place that defines it, so the multiplier and accumulator always match.
    function automatic int prod_width(input int width);
        return 2 * width + 1;
    endfunction

    // Accumulation FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/acc_sat_adder.sv
// ============================================================================
// Module  : acc_sat_adder
// Purpose : Combinational ACC_W-bit signed adder with overflow flag.
//           When MUL_ACC_SAT_EN is defined, an overflowing sum clamps to the
//           most positive or most negative value, following the operand sign.
//           Otherwise the sum wraps (two's complement).
// Ports   : a, b  - signed addends
//           sum   - result (wrapped or clamped)
//           ovf   - signed overflow of a + b
// Config  : MUL_ACC_SAT_EN - enable saturation
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module acc_sat_adder #(
    parameter int ACC_W = 73
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W-1:0] w_raw;

    assign w_raw = a + b;

    // Overflow happens only when both addends share a sign and the result
    // does not.
    assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (w_raw[ACC_W-1] != a[ACC_W-1]);

`ifdef MUL_ACC_SAT_EN
    localparam logic [ACC_W-1:0] c_pos_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_neg_min = {1'b1, {(ACC_W-1){1'b0}}};

    // On overflow both addends share a sign, so a's sign picks the rail.
    assign sum = ovf ? (a[ACC_W-1] ? c_neg_min : c_pos_max) : w_raw;
`else
    assign sum = w_raw;
`endif

endmodule

`default_nettype wire

// File: rtl/mul_result_acc.sv
// ============================================================================
// Module  : mul_result_acc
// Purpose : Accumulates a programmed number of signed products from the
//           shift-add multiplier into a guard-bit-extended accumulator.
//           The final sum is presented with a valid/ready handshake.
// Ports   : clk, reset            - clock, synchronous active-high reset
//           start, num_terms      - begin a run (sampled in IDLE only)
//           product, prod_valid,
//           prod_ready            - product input handshake
//           acc_out, acc_valid,
//           acc_ready             - result output handshake
//           overflow              - sticky overflow for the current run
//           busy                  - FSM is not idle
//           term_count            - products accepted so far
// Config  : MUL_ACC_SAT_EN - saturating accumulation (see acc_sat_adder)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mul_result_acc
    import mul_pkg::*;
#(
    parameter int WIDTH     = c_default_width,
    parameter int PROD_W    = prod_width(WIDTH),
    parameter int ACC_GUARD = 8,
    parameter int ACC_W     = PROD_W + ACC_GUARD,
    parameter int MAX_TERMS = 16,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_terms,
    input  logic [PROD_W-1:0] product,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              overflow,
    output logic              busy,
    output logic [CNT_W-1:0]  term_count
);

    localparam logic [CNT_W-1:0] c_max_terms = CNT_W'(MAX_TERMS);

    acc_state_t       r_state;
    acc_state_t       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_target;
    logic             r_overflow;

    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_add_ovf;
    logic [CNT_W-1:0] w_count_inc;
    logic [CNT_W-1:0] w_target;
    logic             w_xfer;

    // Sign-extend the product into the guard bits.
    assign w_prod_ext  = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    assign w_count_inc = r_count + 1'b1;
    assign w_target    = (num_terms > c_max_terms) ? c_max_terms : num_terms;
    assign w_xfer      = (r_state == ST_ACCUM) && prod_valid;

    acc_sat_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .a   (r_acc),
        .b   (w_prod_ext),
        .sum (w_sum),
        .ovf (w_add_ovf)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_terms == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_xfer && (w_count_inc == r_target)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (acc_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_count    <= '0;
            r_target   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    // Every accepted start, including a zero-term one,
                    // begins a fresh result.
                    if (start) begin
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_target   <= w_target;
                    end
                end
                ST_ACCUM: begin
                    if (prod_valid) begin
                        r_acc   <= w_sum;
                        r_count <= w_count_inc;
                        if (w_add_ovf) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    // DONE holds the result until it is taken.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registers or decoded from state only
    // ------------------------------------------------------------------
    assign prod_ready = (r_state == ST_ACCUM);
    assign acc_valid  = (r_state == ST_DONE);
    assign busy       = (r_state != ST_IDLE);
    assign acc_out    = r_acc;
    assign overflow   = r_overflow;
    assign term_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mul_result_acc.sv
// ============================================================================
// Module  : tb_mul_result_acc
// Purpose : Self-checking bench for mul_result_acc.  A 32-bit instance covers
//           the normal accumulation cases; a 4-bit instance with one guard bit
//           covers overflow (wrap, or clamp under MUL_ACC_SAT_EN).
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mul_result_acc;

    localparam int PW  = 65;
    localparam int AW  = 73;
    localparam int CW  = 5;
    localparam int SPW = 9;
    localparam int SAW = 10;

    typedef struct {
        logic signed [127:0] acc;
        logic                ovf;
        logic [CW-1:0]       cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // 32-bit instance
    logic                 start = 1'b0;
    logic [CW-1:0]        num_terms = '0;
    logic signed [PW-1:0] product = '0;
    logic                 prod_valid = 1'b0;
    logic                 acc_ready = 1'b0;
    logic                 prod_ready;
    logic signed [AW-1:0] acc_out;
    logic                 acc_valid;
    logic                 overflow;
    logic                 busy;
    logic [CW-1:0]        term_count;

    // 4-bit instance
    logic                  s_start = 1'b0;
    logic [CW-1:0]         s_num_terms = '0;
    logic signed [SPW-1:0] s_product = '0;
    logic                  s_prod_valid = 1'b0;
    logic                  s_acc_ready = 1'b0;
    logic                  s_prod_ready;
    logic signed [SAW-1:0] s_acc_out;
    logic                  s_acc_valid;
    logic                  s_overflow;
    logic                  s_busy;
    logic [CW-1:0]         s_term_count;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t                 sb[$];
    logic signed [PW-1:0] prods [0:15];

    always #5 clk = ~clk;

    mul_result_acc #(
        .WIDTH (32)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_terms  (num_terms),
        .product    (product),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .overflow   (overflow),
        .busy       (busy),
        .term_count (term_count)
    );

    mul_result_acc #(
        .WIDTH     (4),
        .ACC_GUARD (1)
    ) u_small (
        .clk        (clk),
        .reset      (reset),
        .start      (s_start),
        .num_terms  (s_num_terms),
        .product    (s_product),
        .prod_valid (s_prod_valid),
        .prod_ready (s_prod_ready),
        .acc_out    (s_acc_out),
        .acc_valid  (s_acc_valid),
        .acc_ready  (s_acc_ready),
        .overflow   (s_overflow),
        .busy       (s_busy),
        .term_count (s_term_count)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one accumulation on the 32-bit instance using prods[].  Called at a
    // negedge; returns at a negedge with the FSM back in IDLE.
    task automatic run_job(input int n, input int gap, input int hold, input bit poke);
        exp_t e;
        exp_t got;
        int   nc;
        int   waited;
        nc    = (n > 16) ? 16 : n;
        e.acc = '0;
        for (int i = 0; i < nc; i++) e.acc = e.acc + prods[i];
        e.ovf = 1'b0;
        e.cnt = CW'(nc);
        sb.push_back(e);

        start     = 1'b1;
        num_terms = CW'(n);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        if (nc == 0) begin
            check("zero_valid_next", acc_valid, 1'b1);
            check("zero_no_prod_ready", prod_ready, 1'b0);
        end else begin
            check("ready_after_start", prod_ready, 1'b1);
        end

        for (int i = 0; i < nc; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    prod_valid = 1'b0;
                    if (poke) begin start = 1'b1; num_terms = 5'd1; end
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            prod_valid = 1'b1;
            product    = prods[i];
            if (poke) begin start = 1'b1; num_terms = 5'd2; end
            @(negedge clk);
            start      = 1'b0;
            prod_valid = 1'b0;
        end

        waited = 0;
        while (!acc_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("valid_latency", waited, 0);
        check("acc_valid", acc_valid, 1'b1);
        got = sb.pop_front();
        check("acc_out", acc_out, got.acc);
        check("overflow", overflow, got.ovf);
        check("term_count", term_count, got.cnt);
        check("prod_ready_done", prod_ready, 1'b0);

        for (int h = 0; h < hold; h++) begin
            if (poke) begin start = 1'b1; num_terms = 5'd1; end
            @(negedge clk);
            start = 1'b0;
            check("hold_acc_out", acc_out, got.acc);
            check("hold_valid", acc_valid, 1'b1);
        end

        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        check("idle_busy", busy, 1'b0);
        check("idle_valid", acc_valid, 1'b0);
    endtask

    initial begin
        logic [95:0] rnd;
        int          m_acc;
        logic        m_ovf;
        int          t;

        repeat (2) @(negedge clk);
        check("rst_prod_ready", prod_ready, 1'b0);
        check("rst_acc_valid", acc_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_acc_out", acc_out, 0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_term_count", term_count, 0);
        check("rst_small_busy", s_busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Three products back to back
        prods[0] = 65'sd15;
        prods[1] = -65'sd4;
        prods[2] = 65'sd4;
        run_job(3, 0, 0, 1'b0);

        // Bubbles and back-pressure
        prods[0] = -65'sd4611686014132420609;
        prods[1] = 65'sd4611686018427387904;
        run_job(2, 3, 5, 1'b0);

        // Zero terms
        run_job(0, 0, 0, 1'b0);

        // num_terms above the maximum clamps to 16
        for (int i = 0; i < 16; i++) begin
            rnd      = {$urandom(), $urandom(), $urandom()};
            prods[i] = rnd[PW-1:0];
        end
        run_job(20, 0, 0, 1'b0);

        // start pulsed during ACCUM and DONE
        for (int i = 0; i < 3; i++) begin
            rnd      = {$urandom(), $urandom(), $urandom()};
            prods[i] = rnd[PW-1:0];
        end
        run_job(3, 2, 3, 1'b1);

        // Reset in the middle of a run
        start     = 1'b1;
        num_terms = 5'd4;
        @(negedge clk);
        start      = 1'b0;
        prod_valid = 1'b1;
        product    = 65'sd100;
        @(negedge clk);
        product = 65'sd200;
        @(negedge clk);
        prod_valid = 1'b0;
        check("mid_term_count", term_count, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_acc_out", acc_out, 0);
        check("mid_rst_term_count", term_count, 0);
        check("mid_rst_prod_ready", prod_ready, 1'b0);
        check("mid_rst_acc_valid", acc_valid, 1'b0);
        prods[0] = 65'sd7;
        run_job(1, 0, 0, 1'b0);

        // Overflow on the 10-bit accumulator: 8 x 64
        m_acc = 0;
        m_ovf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            t = m_acc + 64;
            if (t > 511 || t < -512) begin
                m_ovf = 1'b1;
`ifdef MUL_ACC_SAT_EN
                m_acc = (t > 511) ? 511 : -512;
`else
                m_acc = ((t + 512) & 1023) - 512;
`endif
            end else begin
                m_acc = t;
            end
        end
        s_start     = 1'b1;
        s_num_terms = 5'd8;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_prod_valid = 1'b1;
            s_product    = 9'sd64;
            @(negedge clk);
        end
        s_prod_valid = 1'b0;
        check("ovf_valid", s_acc_valid, 1'b1);
        check("ovf_acc_out", s_acc_out, m_acc);
        check("ovf_flag", s_overflow, m_ovf);
        check("ovf_term_count", s_term_count, 8);
        s_acc_ready = 1'b1;
        @(negedge clk);
        s_acc_ready = 1'b0;
        check("ovf_idle", s_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
